multicycle_controller: RTL
==========================

# multicycle_controller

Main control FSM for the multicycle datapath. It sequences fetch, decode, execute, memory and writeback for each instruction, and drives `ALUOp[1:0]` into the ALU decoder, which turns it into `ALUControl`. It also drives every datapath strobe and mux select, and runs a request/ready handshake with the unified instruction/data memory.

## Interface
Parameters:
- `WAIT_MAX`, default 15: maximum cycles `MemReq` may stay high without `MemReady` before a bus error.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 3: instruction opcode from the IR. Encodings:
  - 000 R-type; 001 I-group A; 010 I-group B
  - 011 ST; 100 BEQ; 101 JMP; 110 HALT; 111 unassigned
- `funct3` in 2: from the IR; `op`=001 with `funct3`=00 is LD.
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory completes the current access.
- `ALUOp` out 2: 00 I-type/address, 01 branch compare, 10 R-type, 11 plain ADD.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 RegA.
- `ALUSrcB` out 2: 00 RegB, 01 Imm, 10 constant 1.
- `ResultSrc` out 2: 00 ALUOut register, 01 MemData, 10 ALUResult.
- `AdrSrc` out 1: 0 PC, 1 ALUOut.
- `MemReq` out 1, `MemWrite` out 1, `IRWrite` out 1, `PCWrite` out 1, `RegWrite` out 1.
- `Halted` out 1: sticky.
- `BusError` out 1: sticky.
- `IllegalOp` out 1: sticky; only present when the configuration macro is defined.

## Operation
- State is registered. Outputs are decoded combinationally from state; `PCWrite` and `IRWrite` also depend on `MemReady`, and the BEQ `PCWrite` depends on `Zero`.
- Every output not listed for a state is 0.
- FETCH:
  - Outputs: `MemReq`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=11, `ResultSrc`=10.
  - `IRWrite`=`PCWrite`=`MemReady`.
  - Next state is DECODE when `MemReady`=1; otherwise stay in FETCH.
- DECODE:
  - Outputs: `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=11 (branch/jump target into ALUOut).
  - Next state by `op`:
    - 000 → EXECR
    - 001 with `funct3`=00, or 011 → MEMADR
    - 001 (other `funct3`) or 010 → EXECI
    - 100 → BEQ; 101 → JUMP; 110 → HALT; 111 → per Configuration.
- EXECR: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10; next ALUWB.
- EXECI: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00; next ALUWB.
- ALUWB: `RegWrite`=1, `ResultSrc`=00; next FETCH.
- MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00; next MEMREAD if `op`=001, MEMWRITE if `op`=011.
- MEMREAD: `MemReq`=1, `AdrSrc`=1; wait for `MemReady`, then MEMWB.
- MEMWB: `RegWrite`=1, `ResultSrc`=01; next FETCH.
- MEMWRITE: `MemReq`=1, `MemWrite`=1, `AdrSrc`=1; wait for `MemReady`, then FETCH.
- BEQ:
  - Outputs: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00, `PCWrite`=`Zero`.
  - Next FETCH.
- JUMP: `PCWrite`=1, `ResultSrc`=00; next FETCH.
- HALT: `Halted`=1; all strobes low; stays in HALT until `reset`.
- Memory wait counter:
  - Clears on entry to each memory state and counts cycles with `MemReq`=1 and `MemReady`=0.
  - On reaching `WAIT_MAX`: set `BusError`, go to HALT, and drop `MemReq` the next cycle.
  - The timeout write is never issued to the PC or IR.

## Timing
- Reset: on a rising edge with `reset`=1, state becomes FETCH, the counter clears, and all sticky flags clear. While `reset`=1, all outputs are forced to 0. Reset asserted mid-access abandons the access.
- Latency with zero-wait memory (`MemReady` high in the first requesting cycle):
  - R/I ALU: 4 cycles; LD: 5; ST: 4; BEQ: 3; JMP: 3.
  - Each wait cycle adds 1.
- `MemReady` is ignored when `MemReq`=0.
- `MemReady` and timeout in the same cycle: `MemReady` wins.
- `MemReq`, `MemWrite` and `AdrSrc` are stable for the whole access.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - `op`=111 in DECODE goes to HALT and sets the sticky `IllegalOp`.
- `MC_ILLEGAL_TRAP_EN` undefined:
  - `op`=111 is a NOP: DECODE → FETCH, 2 cycles total.
  - The `IllegalOp` port does not exist.

## Test plan
- ADD (`op`=000), `MemReady` tied 1 → FETCH, DECODE, EXECR, ALUWB. `ALUOp`=10 in cycle 3; `RegWrite`=1 only in cycle 4.
- LD (`op`=001, `funct3`=00), `MemReady` delayed 3 cycles in MEMREAD → `MemReq`/`AdrSrc`=1 held 4 cycles; `RegWrite` with `ResultSrc`=01 one cycle later; 8 cycles total.
- BEQ with `Zero`=1, then with `Zero`=0 → `ALUOp`=01 in cycle 3; `PCWrite`=1 and 0 respectively.
- `MemReady` held 0 in FETCH with `WAIT_MAX`=15 → `BusError`=1 and `Halted`=1 after 15 cycles; no `IRWrite`/`PCWrite` pulse.
- `op`=111 → with the macro: `IllegalOp`=1 and HALT; without it: back to FETCH after 2 cycles.
- `reset` pulsed during MEMWRITE wait → next cycle FETCH, `MemWrite`=0, flags cleared.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle datapath with a memory request/ready handshake and timeout.
// Optional MC_ILLEGAL_TRAP_EN: op 111 halts and sets sticky IllegalOp instead of acting as a NOP.
module multicycle_controller #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] op,
   input  logic [1:0] funct3,
   input  logic       Zero,
   input  logic       MemReady,
   output logic [1:0] ALUOp,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       AdrSrc,
   output logic       MemReq,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       Halted,
`ifdef MC_ILLEGAL_TRAP_EN
   output logic       IllegalOp,
`endif
   output logic       BusError
);

   localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WAIT_MAX - 1);

   typedef enum logic [3:0] {
      StFetch, StDecode, StExecR, StExecI, StAluWb, StMemAdr,
      StMemRead, StMemWb, StMemWrite, StBeq, StJump, StHalt
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            bus_err_q, bus_err_d;
   logic            illegal_q, illegal_d;
   logic            mem_state;

   assign mem_state = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StFetch;
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      bus_err_d = bus_err_q;
      illegal_d = illegal_q;
      unique case (state_q)
         StFetch:    if (MemReady) state_d = StDecode;
         StDecode: begin
            unique case (op)
               3'b000: state_d = StExecR;
               3'b001: state_d = (funct3 == 2'b00) ? StMemAdr : StExecI;
               3'b010: state_d = StExecI;
               3'b011: state_d = StMemAdr;
               3'b100: state_d = StBeq;
               3'b101: state_d = StJump;
               3'b110: state_d = StHalt;
               3'b111: begin
`ifdef MC_ILLEGAL_TRAP_EN
                  state_d   = StHalt;
                  illegal_d = 1'b1;
`else
                  state_d   = StFetch;
`endif
               end
               default: state_d = StFetch;
            endcase
         end
         StExecR,
         StExecI:    state_d = StAluWb;
         StMemAdr:   state_d = (op == 3'b001) ? StMemRead : StMemWrite;
         StMemRead:  if (MemReady) state_d = StMemWb;
         StMemWrite: if (MemReady) state_d = StFetch;
         StHalt:     state_d = StHalt;
         default:    state_d = StFetch;
      endcase
      // A ready in the same cycle as the last allowed wait completes normally.
      if (mem_state && !MemReady) begin
         if (cnt_q == CntLast) begin
            state_d   = StHalt;
            bus_err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      ALUOp     = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      AdrSrc    = 1'b0;
      MemReq    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      unique case (state_q)
         StFetch: begin
            MemReq    = 1'b1;
            ALUSrcB   = 2'b10;
            ALUOp     = 2'b11;
            ResultSrc = 2'b10;
            IRWrite   = MemReady;
            PCWrite   = MemReady;
         end
         StDecode: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b11;
         end
         StExecR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
         end
         StExecI,
         StMemAdr: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         StAluWb:    RegWrite = 1'b1;
         StMemRead: begin
            MemReq = 1'b1;
            AdrSrc = 1'b1;
         end
         StMemWb: begin
            RegWrite  = 1'b1;
            ResultSrc = 2'b01;
         end
         StMemWrite: begin
            MemReq   = 1'b1;
            MemWrite = 1'b1;
            AdrSrc   = 1'b1;
         end
         StBeq: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            PCWrite = Zero;
         end
         StJump:     PCWrite = 1'b1;
         default: ;
      endcase
      Halted   = (state_q == StHalt);
      BusError = bus_err_q;
`ifdef MC_ILLEGAL_TRAP_EN
      IllegalOp = illegal_q;
`endif
      if (reset) begin
         ALUOp     = 2'b00;
         ALUSrcA   = 2'b00;
         ALUSrcB   = 2'b00;
         ResultSrc = 2'b00;
         AdrSrc    = 1'b0;
         MemReq    = 1'b0;
         MemWrite  = 1'b0;
         IRWrite   = 1'b0;
         PCWrite   = 1'b0;
         RegWrite  = 1'b0;
         Halted    = 1'b0;
         BusError  = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
         IllegalOp = 1'b0;
`endif
      end
   end

endmodule
